// File: rtl/buf0_rgb_unpack.sv
// buf0_rgb_unpack: drains Buffer0 bytes, steers them into R/G/B and emits one 24-bit pixel per three bytes.
module buf0_rgb_unpack #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] buf_data,
    input  logic          buf_valid,
    output logic          buf_ready,
    input  logic          resync,
    output logic [DW-1:0] pix_r,
    output logic [DW-1:0] pix_g,
    output logic [DW-1:0] pix_b,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          sel_r,
    output logic          sel_g,
    output logic          sel_b,
    output logic [CW-1:0] pix_count
);
    typedef enum logic [2:0] {S_R = 3'b001, S_G = 3'b010, S_B = 3'b100} state_t;

    state_t        state;
    logic [DW-1:0] r_hold, g_hold;
    logic          accept, deliver;

    // One-hot state encoding doubles as the registered channel selects.
    assign {sel_b, sel_g, sel_r} = state;
    assign buf_ready = (state != S_B) || !pix_valid || pix_ready;
    assign accept    = buf_valid && buf_ready;
    assign deliver   = pix_valid && pix_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_R;
            r_hold    <= '0;
            g_hold    <= '0;
            pix_r     <= '0;
            pix_g     <= '0;
            pix_b     <= '0;
            pix_valid <= 1'b0;
            pix_count <= '0;
        end else begin
            if (resync) begin
                g_hold <= '0;
                r_hold <= accept ? buf_data : '0;
                state  <= accept ? S_G : S_R;
            end else if (accept) begin
                case (state)
                    S_R: begin
                        r_hold <= buf_data;
                        state  <= S_G;
                    end
                    S_G: begin
                        g_hold <= buf_data;
                        state  <= S_B;
                    end
                    default: state <= S_R;
                endcase
            end
            // A B byte landing on a delivering cycle refills the output register in place.
            if (accept && state == S_B && !resync) begin
                pix_r     <= r_hold;
                pix_g     <= g_hold;
                pix_b     <= buf_data;
                pix_valid <= 1'b1;
            end else if (deliver) begin
                pix_valid <= 1'b0;
            end
            if (deliver) pix_count <= pix_count + CW'(1);
        end
    end
endmodule

// File: tb/tb_buf0_rgb_unpack.sv
// tb_buf0_rgb_unpack: directed scoreboard bench; expected pixels queued at stimulus, popped by a delivery monitor.
module tb_buf0_rgb_unpack;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] buf_data = '0;
    logic          buf_valid = 1'b0;
    logic          buf_ready;
    logic          resync = 1'b0;
    logic [DW-1:0] pix_r, pix_g, pix_b;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          sel_r, sel_g, sel_b;
    logic [CW-1:0] pix_count;

    int checks = 0;
    int errors = 0;
    logic [3*DW-1:0] exp_q[$];
    logic [CW-1:0]   exp_cnt = '0;

    always #5 clk = ~clk;

    buf0_rgb_unpack #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .buf_data(buf_data), .buf_valid(buf_valid),
        .buf_ready(buf_ready), .resync(resync), .pix_r(pix_r), .pix_g(pix_g),
        .pix_b(pix_b), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .sel_r(sel_r), .sel_g(sel_g), .sel_b(sel_b), .pix_count(pix_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every delivery must match the oldest expected pixel and the running count.
    always @(negedge clk) begin
        if (rst_n && pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pixel", {8'h0, pix_r, pix_g, pix_b}, 32'hFFFFFFFF);
            end else begin
                chk("pixel", {8'h0, pix_r, pix_g, pix_b}, {8'h0, exp_q.pop_front()});
                chk("pix_count", 32'(pix_count), 32'(exp_cnt));
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    task automatic push(input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b);
        exp_q.push_back({r, g, b});
    endtask

    task automatic send(input logic [DW-1:0] b);
        buf_data  = b;
        buf_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (buf_ready) begin
                @(posedge clk);
                #1;
                buf_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 32'(b), 32'hFFFFFFFF);
        buf_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(2);
        chk("rst_sel", {sel_b, sel_g, sel_r}, 3'b001);
        chk("rst_valid", pix_valid, 0);
        chk("rst_count", pix_count, 0);
        chk("rst_ready", buf_ready, 1);
        chk("rst_pix", {pix_r, pix_g, pix_b}, 0);
        rst_n = 1'b1;
        idle(1);

        // Basic pixel at full rate
        pix_ready = 1'b1;
        push(8'h11, 8'h22, 8'h33);
        send(8'h11);
        chk("sel_g", {sel_b, sel_g, sel_r}, 3'b010);
        send(8'h22);
        chk("sel_b", {sel_b, sel_g, sel_r}, 3'b100);
        send(8'h33);
        chk("sel_r", {sel_b, sel_g, sel_r}, 3'b001);
        chk("lat_valid", pix_valid, 1);
        idle(2);
        chk("count1", pix_count, 1);
        chk("drained", pix_valid, 0);

        // Backpressure
        pix_ready = 1'b0;
        push(8'h01, 8'h02, 8'h03);
        push(8'h04, 8'h05, 8'h06);
        send(8'h01); send(8'h02); send(8'h03);
        send(8'h04); send(8'h05);
        buf_data = 8'h06; buf_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready", buf_ready, 0);
        chk("bp_hold", {pix_valid, pix_r, pix_g, pix_b}, {1'b1, 24'h010203});
        idle(1);
        @(negedge clk);
        chk("bp_hold2", {pix_valid, pix_r, pix_b}, {1'b1, 16'h0103});
        chk("bp_sel_b", sel_b, 1);
        @(posedge clk); #1;
        pix_ready = 1'b1;
        send(8'h06);
        chk("bp_next", {pix_valid, pix_r, pix_g, pix_b}, {1'b1, 24'h040506});
        idle(2);

        // Resync discards partial AA/BB; CC is taken as R
        push(8'hCC, 8'hDD, 8'hEE);
        send(8'hAA); send(8'hBB);
        resync = 1'b1;
        send(8'hCC);
        resync = 1'b0;
        chk("rs_sel", sel_g, 1);
        send(8'hDD); send(8'hEE);
        idle(2);
        chk("rs_q", exp_q.size(), 0);

        // Async reset while in S_G with a pending pixel
        pix_ready = 1'b0;
        push(8'h71, 8'h72, 8'h73);
        send(8'h71); send(8'h72); send(8'h73); send(8'h74);
        chk("pre_rst", {pix_valid, sel_g}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", pix_valid, 0);
        chk("arst_sel", {sel_b, sel_g, sel_r}, 3'b001);
        chk("arst_count", pix_count, 0);
        exp_q.delete();
        exp_cnt = '0;
        idle(1);
        rst_n = 1'b1;
        pix_ready = 1'b1;
        push(8'h81, 8'h82, 8'h83);
        send(8'h81); send(8'h82); send(8'h83);
        idle(2);
        chk("post_rst_count", pix_count, 1);

        // Count wrap: 16 more deliveries pass through 15 and back to 1
        for (int i = 0; i < 16; i++) begin
            push(8'(3 * i), 8'(3 * i + 1), 8'(3 * i + 2));
            send(8'(3 * i)); send(8'(3 * i + 1)); send(8'(3 * i + 2));
        end
        idle(2);
        chk("wrap_count", pix_count, 1);

        // Gappy input with random backpressure
        for (int p = 0; p < 8; p++) push(8'h40 + 8'(3 * p), 8'h41 + 8'(3 * p), 8'h42 + 8'(3 * p));
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 3)) begin
                pix_ready = 1'($urandom_range(0, 1));
                idle(1);
            end
            send(8'h40 + 8'(k));
        end
        pix_ready = 1'b1;
        for (int t = 0; t < 50 && (exp_q.size() != 0 || pix_valid); t++) idle(1);
        chk("final_q", exp_q.size(), 0);
        chk("final_count", pix_count, 32'((1 + 16 + 8) % 16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
